// File: rtl/rf_pkg.sv
// Shared defaults for the scoreboarded register file.
package rf_pkg;
  localparam int RF_DATA_W   = 32;
  localparam int RF_NUM_REGS = 64;
  localparam int ZERO_ADDR   = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits: issue reserves a destination, writeback clears it.
// Busy lookups are combinational; the busy vector and busy_cnt update at the edge. No flow control.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              rs_busy,
  output logic              rt_busy,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;
  logic                set_ok;
  logic                clr_ok;
  logic                inc;
  logic                dec;

  always_comb begin
    set_ok   = rsv_en && !(ZERO_REG && (rsv_addr == ADDR_W'(ZERO_ADDR)));
    clr_ok   = we && !(ZERO_REG && (wr_addr == ADDR_W'(ZERO_ADDR)));
    busy_nxt = busy;
    if (clr_ok) busy_nxt[wr_addr] = 1'b0;
    // Reserve is applied last: a new producer supersedes the one writing back now.
    if (set_ok) busy_nxt[rsv_addr] = 1'b1;
    inc = set_ok && !busy[rsv_addr];
    dec = clr_ok && busy[wr_addr] && !(set_ok && (rsv_addr == wr_addr));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_nxt;
      case ({inc, dec})
        2'b10:   busy_cnt <= busy_cnt + (ADDR_W+1)'(1);
        2'b01:   busy_cnt <= busy_cnt - (ADDR_W+1)'(1);
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

  assign rs_busy = busy[rs_addr];
  assign rt_busy = busy[rt_addr];

endmodule

// File: rtl/reg_file_sb.sv
// Register file with two combinational read ports, one write port, optional bypass and a busy scoreboard.
// Reads are zero latency, writes land at the next edge. No flow control; decode stalls on the busy outputs.
module reg_file_sb
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter bit BYPASS   = 1'b1,
  parameter bit ZERO_REG = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic              rs_busy,
  output logic              rt_busy,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W:0]   busy_cnt
);

  logic [DATA_W-1:0] mem [NUM_REGS];
  logic              wr_ok;
  logic              rs_zero;
  logic              rt_zero;
  logic              rs_fwd;
  logic              rt_fwd;
  logic              rs_busy_raw;
  logic              rt_busy_raw;

  assign wr_ok   = we && !(ZERO_REG && (wr_addr == ADDR_W'(ZERO_ADDR)));
  assign rs_zero = ZERO_REG && (rs_addr == ADDR_W'(ZERO_ADDR));
  assign rt_zero = ZERO_REG && (rt_addr == ADDR_W'(ZERO_ADDR));
  assign rs_fwd  = BYPASS && wr_ok && (rs_addr == wr_addr);
  assign rt_fwd  = BYPASS && wr_ok && (rt_addr == wr_addr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    end else if (wr_ok) begin
      mem[wr_addr] <= wr_data;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG)
  ) u_sb (
    .clk      (clk),
    .rst      (rst),
    .rsv_en   (rsv_en),
    .rsv_addr (rsv_addr),
    .we       (we),
    .wr_addr  (wr_addr),
    .rs_addr  (rs_addr),
    .rt_addr  (rt_addr),
    .rs_busy  (rs_busy_raw),
    .rt_busy  (rt_busy_raw),
    .busy_cnt (busy_cnt)
  );

  // A forwarded result is by definition no longer outstanding, so it also masks busy.
  always_comb begin
    rs_data = rs_zero ? '0 : (rs_fwd ? wr_data : mem[rs_addr]);
    rt_data = rt_zero ? '0 : (rt_fwd ? wr_data : mem[rt_addr]);
    rs_busy = !rs_zero && !rs_fwd && rs_busy_raw;
    rt_busy = !rt_zero && !rt_fwd && rt_busy_raw;
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Randomized and directed check of reg_file_sb (bypass and non-bypass builds) against a behavioural model.
module tb_reg_file_sb;
  localparam int DW = 32;
  localparam int NR = 64;
  localparam int AW = 6;

  logic          clk;
  logic          rst;
  logic [AW-1:0] rs_addr, rt_addr, rsv_addr, wr_addr;
  logic          rsv_en, we;
  logic [DW-1:0] wr_data;

  logic [DW-1:0] b_rs_data, b_rt_data, n_rs_data, n_rt_data;
  logic          b_rs_busy, b_rt_busy, n_rs_busy, n_rt_busy;
  logic [AW:0]   b_cnt, n_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // Reference state: plain arrays updated from the behavioural rules.
  logic [DW-1:0] m_mem  [NR];
  bit            m_busy [NR];

  reg_file_sb #(.BYPASS(1'b1), .ZERO_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(b_rs_data), .rt_data(b_rt_data), .rs_busy(b_rs_busy), .rt_busy(b_rt_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_cnt(b_cnt)
  );

  reg_file_sb #(.BYPASS(1'b0), .ZERO_REG(1'b1)) dut_nb (
    .clk(clk), .rst(rst), .rs_addr(rs_addr), .rt_addr(rt_addr),
    .rs_data(n_rs_data), .rt_data(n_rt_data), .rs_busy(n_rs_busy), .rt_busy(n_rt_busy),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy_cnt(n_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return '0;
    if (byp && we && wr_addr == a) return wr_data;
    return m_mem[a];
  endfunction

  function automatic bit exp_busy(input logic [AW-1:0] a, input bit byp);
    if (a == 0) return 1'b0;
    if (byp && we && wr_addr == a) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int i = 0; i < NR; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (we && wr_addr != 0) begin
        m_mem[wr_addr]  = wr_data;
        m_busy[wr_addr] = 1'b0;
      end
      if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("byp rs_data", 64'(b_rs_data), 64'(exp_data(rs_addr, 1'b1)));
      chk("byp rt_data", 64'(b_rt_data), 64'(exp_data(rt_addr, 1'b1)));
      chk("byp rs_busy", 64'(b_rs_busy), 64'(exp_busy(rs_addr, 1'b1)));
      chk("byp rt_busy", 64'(b_rt_busy), 64'(exp_busy(rt_addr, 1'b1)));
      chk("byp busy_cnt", 64'(b_cnt), 64'(exp_cnt()));
      chk("nb rs_data", 64'(n_rs_data), 64'(exp_data(rs_addr, 1'b0)));
      chk("nb rt_data", 64'(n_rt_data), 64'(exp_data(rt_addr, 1'b0)));
      chk("nb rs_busy", 64'(n_rs_busy), 64'(exp_busy(rs_addr, 1'b0)));
      chk("nb rt_busy", 64'(n_rt_busy), 64'(exp_busy(rt_addr, 1'b0)));
      chk("nb busy_cnt", 64'(n_cnt), 64'(exp_cnt()));
    end
  end

  task automatic drive(input logic r, input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic rv, input logic [AW-1:0] ra,
                       input logic [AW-1:0] sa, input logic [AW-1:0] ta);
    @(posedge clk);
    #1;
    rst = r; we = w; wr_addr = wa; wr_data = wd;
    rsv_en = rv; rsv_addr = ra; rs_addr = sa; rt_addr = ta;
    @(negedge clk);
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR-1));
    return AW'($urandom_range(0, 11));
  endfunction

  initial begin
    rst = 1'b1; we = 1'b0; wr_addr = '0; wr_data = '0;
    rsv_en = 1'b0; rsv_addr = '0; rs_addr = '0; rt_addr = '0;
    repeat (2) @(posedge clk);
    chk_en = 1'b1;

    // Reset state across every address.
    for (int a = 0; a < NR; a++) begin
      drive(0, 0, 0, 0, 0, 0, AW'(a), AW'(NR-1-a));
      chk("reset rs_data", 64'(b_rs_data), 64'h0);
      chk("reset rt_busy", 64'(b_rt_busy), 64'h0);
      chk("reset busy_cnt", 64'(b_cnt), 64'h0);
    end

    // Same-cycle forwarding versus stored read.
    drive(0, 1, 5, 32'hDEADBEEF, 0, 0, 5, 0);
    chk("fwd byp rs_data", 64'(b_rs_data), 64'hDEADBEEF);
    chk("fwd nb rs_data", 64'(n_rs_data), 64'h0);
    drive(0, 0, 0, 0, 0, 0, 5, 0);
    chk("fwd nb next rs_data", 64'(n_rs_data), 64'hDEADBEEF);

    // Register zero ignores writes and reservations.
    drive(0, 1, 0, 32'h1234, 0, 0, 0, 0);
    chk("zero wr byp rs_data", 64'(b_rs_data), 64'h0);
    drive(0, 0, 0, 0, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("zero rs_data", 64'(n_rs_data), 64'h0);
    chk("zero rsv busy_cnt", 64'(b_cnt), 64'h0);

    // Reserve then writeback.
    drive(0, 0, 0, 0, 1, 7, 0, 7);
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    chk("rsv7 rt_busy", 64'(b_rt_busy), 64'h1);
    chk("rsv7 busy_cnt", 64'(b_cnt), 64'h1);
    drive(0, 1, 7, 32'hA5A5A5A5, 0, 0, 0, 7);
    chk("wb7 nb rt_busy", 64'(n_rt_busy), 64'h1);
    chk("wb7 byp rt_busy", 64'(b_rt_busy), 64'h0);
    drive(0, 0, 0, 0, 0, 0, 0, 7);
    chk("wb7 rt_busy", 64'(n_rt_busy), 64'h0);
    chk("wb7 rt_data", 64'(n_rt_data), 64'hA5A5A5A5);
    chk("wb7 busy_cnt", 64'(b_cnt), 64'h0);

    // Reserve and write the same register in one cycle: reserve wins.
    drive(0, 0, 0, 0, 1, 9, 0, 0);
    drive(0, 1, 9, 32'h55, 1, 9, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    chk("rsvwr9 rs_data", 64'(n_rs_data), 64'h55);
    chk("rsvwr9 rs_busy", 64'(n_rs_busy), 64'h1);
    chk("rsvwr9 busy_cnt", 64'(b_cnt), 64'h1);
    drive(0, 1, 9, 32'h66, 0, 0, 9, 0);
    drive(0, 0, 0, 0, 0, 0, 9, 0);
    chk("clr9 busy_cnt", 64'(b_cnt), 64'h0);

    // Reset overrides a concurrent write and drops reservations.
    drive(0, 0, 0, 0, 1, 3, 0, 0);
    drive(0, 0, 0, 0, 1, 4, 0, 0);
    drive(0, 0, 0, 0, 1, 6, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 4, 3);
    chk("rsv346 busy_cnt", 64'(b_cnt), 64'h3);
    drive(1, 1, 4, 32'hCAFEF00D, 0, 0, 4, 3);
    drive(0, 0, 0, 0, 0, 0, 4, 3);
    chk("rst busy_cnt", 64'(b_cnt), 64'h0);
    chk("rst rs_data", 64'(n_rs_data), 64'h0);
    chk("rst rt_busy", 64'(n_rt_busy), 64'h0);

    // Fill the scoreboard: the count tops out at NUM_REGS-1.
    for (int a = 0; a < NR; a++) drive(0, 0, 0, 0, 1, AW'(a), 0, 0);
    drive(0, 0, 0, 0, 1, 63, 0, 0);
    chk("full busy_cnt", 64'(b_cnt), 64'(NR-1));
    drive(1, 0, 0, 0, 0, 0, 0, 0);

    // Randomized traffic concentrated on a few registers to provoke hazards.
    for (int i = 0; i < 3000; i++) begin
      drive(logic'($urandom_range(0, 99) == 0), logic'($urandom_range(0, 1)), rnd_addr(), $urandom(),
            logic'($urandom_range(0, 9) < 4), rnd_addr(), rnd_addr(), rnd_addr());
    end

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
